// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style main controller: one state register, all outputs decoded
// combinationally from state, enable and the current instruction fields.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal_op,
    output logic       instr_done
);

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
        StExecR, StExecI, StAluWb, StBeq, StJal
    } state_t;

    state_t state_q;

    logic is_lw, is_sw, is_r, is_i, is_beq, is_jal, is_illegal;

    assign is_lw      = (op == 7'b0000011);
    assign is_sw      = (op == 7'b0100011);
    assign is_r       = (op == 7'b0110011);
    assign is_i       = (op == 7'b0010011);
    assign is_beq     = (op == 7'b1100011);
    assign is_jal     = (op == 7'b1101111);
    assign is_illegal = !(is_lw | is_sw | is_r | is_i | is_beq | is_jal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else if (en) begin
            case (state_q)
                StFetch:   state_q <= StDecode;
                StDecode: begin
                    if (is_lw || is_sw) state_q <= StMemAdr;
                    else if (is_r)      state_q <= StExecR;
                    else if (is_i)      state_q <= StExecI;
                    else if (is_beq)    state_q <= StBeq;
                    else if (is_jal)    state_q <= StJal;
                    else                state_q <= StFetch;
                end
                StMemAdr:  state_q <= is_lw ? StMemRead : StMemWrite;
                StMemRead: state_q <= StMemWb;
                StExecR,
                StExecI,
                StJal:     state_q <= StAluWb;
                default:   state_q <= StFetch;
            endcase
        end
    end

    logic       pc_update, branch, ir_wr, reg_wr, mem_wr, done;
    logic [1:0] alu_op;
    logic       act;

    // Strobes are also masked during reset, since the reset state (fetch) drives them.
    assign act = en & rst_n;

    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_wr     = 1'b0;
        reg_wr    = 1'b0;
        mem_wr    = 1'b0;
        done      = 1'b0;
        alu_op    = 2'b00;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        case (state_q)
            StFetch: begin
                ir_wr     = 1'b1;
                pc_update = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                done    = is_illegal;
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            StMemRead: AdrSrc = 1'b1;
            StMemWb: begin
                ResultSrc = 2'b01;
                reg_wr    = 1'b1;
                done      = 1'b1;
            end
            StMemWrite: begin
                AdrSrc = 1'b1;
                mem_wr = 1'b1;
                done   = 1'b1;
            end
            StExecR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            StExecI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            StAluWb: begin
                reg_wr = 1'b1;
                done   = 1'b1;
            end
            StBeq: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
                done    = 1'b1;
            end
            StJal: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCWrite    = act & (pc_update | (branch & Zero));
    assign IRWrite    = act & ir_wr;
    assign RegWrite   = act & reg_wr;
    assign MemWrite   = act & mem_wr;
    assign instr_done = act & done;
    assign illegal_op = act & (state_q == StDecode) & is_illegal;

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        if (is_sw)       ImmSrc = 2'b01;
        else if (is_beq) ImmSrc = 2'b10;
        else if (is_jal) ImmSrc = 2'b11;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have the port clk, input, width 1, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, width 1, an asynchronous active-low reset.
REQ-003 The block SHALL have the port en, input, width 1, the run enable; when low the FSM holds its state and all write strobes are forced low.
REQ-004 The block SHALL have the port op, input, width 7, the opcode from the instruction register.
REQ-005 The block SHALL have the port funct3, input, width 3, instruction bits 14:12.
REQ-006 The block SHALL have the port funct7b5, input, width 1, instruction bit 30.
REQ-007 The block SHALL have the port Zero, input, width 1, the ALU zero flag.
REQ-008 The block SHALL have the outputs PCWrite, AdrSrc, MemWrite, IRWrite and RegWrite, each output, width 1, the datapath strobes and selects.
REQ-009 The block SHALL have the outputs ResultSrc, ALUSrcA, ALUSrcB and ImmSrc, each output, width 2, the datapath mux selects.
REQ-010 The block SHALL have the port ALUControl, output, width 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-011 The block SHALL have the ports illegal_op and instr_done, each output, width 1, one-cycle status pulses.

Function
REQ-012 The FSM states SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ and JAL.
REQ-013 Opcodes SHALL be lw 0000011, sw 0100011, R-type 0110011, I-type 0010011, beq 1100011 and jal 1101111; any other opcode is illegal.
REQ-014 Transitions SHALL be: FETCH->DECODE; DECODE->MEMADR (lw/sw), EXECR, EXECI, BEQ, JAL, or FETCH (illegal); MEMADR->MEMREAD (lw) or MEMWRITE (sw); MEMREAD->MEMWB; EXECR and EXECI->ALUWB; JAL->ALUWB; MEMWB, MEMWRITE, ALUWB and BEQ->FETCH.
REQ-015 State outputs SHALL be, with unlisted signals 0:
- FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
REQ-016 PCWrite SHALL equal PCUpdate OR (Branch AND Zero), gated by en.
REQ-017 ALUControl SHALL be decoded as follows:
- ALUOp 00: 000.
- ALUOp 01: 001.
- ALUOp 10, funct3 000: 001 if op[5] AND funct7b5, else 000.
- ALUOp 10, funct3 010: 101.
- ALUOp 10, funct3 110: 011.
- ALUOp 10, funct3 111: 010.
- ALUOp 10, any other funct3: 000.
REQ-018 ImmSrc SHALL be combinational from op: I-type/lw 00, sw 01, beq 10, jal 11, illegal 00.
REQ-019 illegal_op SHALL pulse high for exactly the DECODE cycle holding an illegal opcode; no strobe is asserted for that instruction.
REQ-020 instr_done SHALL pulse high in the final state of each instruction (MEMWB, MEMWRITE, ALUWB, BEQ) and in DECODE on an illegal opcode.
REQ-021 Latency in cycles with en=1 SHALL be: lw 5, sw 4, R/I 4, beq 3, jal 4, illegal 2.
REQ-022 With en=0 the state SHALL hold, mux selects SHALL keep their state values, and PCWrite, IRWrite, MemWrite, RegWrite and instr_done SHALL be 0; operation resumes unchanged when en returns to 1.
REQ-023 All outputs SHALL be combinational functions of state, en, op, funct3, funct7b5 and Zero; state is the only register.

Reset
REQ-024 While rst_n=0, state SHALL be FETCH immediately (asynchronously), and all write strobes, illegal_op and instr_done SHALL be 0.
REQ-025 A reset asserted mid-instruction SHALL abandon the instruction, and the first rising clk edge after deassertion SHALL leave FETCH.

Verification
REQ-026 Scenario: reset release, op=0000011, en=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 with ResultSrc=01 in cycle 5 only; instr_done in cycle 5.
REQ-027 Scenario: R-type with funct3=000 and funct7b5=1 -> ALUControl=001 in EXECR; RegWrite=1 in ALUWB; funct7b5=0 -> 000.
REQ-028 Scenario: beq with Zero=1 in the BEQ cycle -> PCWrite=1; with Zero=0 -> PCWrite=0; next state FETCH in both cases.
REQ-029 Scenario: op=1111111 -> illegal_op=1 and instr_done=1 in DECODE, then FETCH; no MemWrite or RegWrite asserted.
REQ-030 Scenario: sw with en=0 for 3 cycles in MEMADR -> state held, MemWrite=0; after en returns to 1, MEMWRITE asserts MemWrite=1 for one cycle.
REQ-031 Scenario: rst_n pulsed low during MEMREAD -> state FETCH asynchronously, strobes 0; after release, a normal fetch occurs with IRWrite=1 and PCWrite=1.
